bram_capture_ctrl: RTL and testbench
====================================

Name: bram_capture_ctrl

Overview:
Master-side controller that drives the single-port BRAM wrapper (write_en/read_en/addr/write_data in, read_data/valid out, one-cycle read latency). Captures a free-running sample stream into BRAM as a circular buffer. On stop, it dumps the captured window oldest-first on a valid/ready output stream. Sits between the packet/sample tap and the host readout path in fpgashark.

Parameters:
ADDR_WIDTH, 10, BRAM address width; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 16, sample/BRAM word width

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
start  in  1  pulse: clear pointers, enter CAPTURE (honoured only in IDLE)
stop  in  1  pulse: end CAPTURE, enter DUMP (ignored outside CAPTURE)
in_valid  in  1  sample strobe; no backpressure
in_data  in  DATA_WIDTH  sample
out_valid  out  1  dump word valid
out_ready  in  1  downstream accept
out_data  out  DATA_WIDTH  dump word
out_last  out  1  marks final dump word
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after last dump word accepted
wrap_count  out  16  overwritten-word count (see Optional Feature)
mem_write_en  out  1  to BRAM write_en
mem_read_en  out  1  to BRAM read_en
mem_addr  out  ADDR_WIDTH  to BRAM addr
mem_write_data  out  DATA_WIDTH  to BRAM write_data
mem_read_data  in  DATA_WIDTH  from BRAM read_data
mem_valid  in  1  from BRAM valid (asserted one cycle after mem_read_en)

Behaviour:
- Reset (async, rst=1): state IDLE; wr_ptr, rd_ptr, count, issued, in-flight flag, buffer cleared; all outputs 0.
- States: IDLE -> CAPTURE on start. CAPTURE -> DUMP on stop, or -> IDLE with done pulse if count==0. DUMP -> IDLE after last word handshake.
- CAPTURE: each in_valid drives a same-cycle combinational write: mem_write_en=1, mem_addr=wr_ptr, mem_write_data=in_data. wr_ptr increments modulo depth. count saturates at depth.
- Wrap: when count==depth, the write overwrites the oldest word. Oldest index is always wr_ptr - count (mod depth).
- stop and in_valid in the same cycle: the sample is written, then DUMP starts next cycle.
- start while count==0 and in_valid asserted: sample is captured the cycle after start, never on the start cycle itself.
- DUMP entry: rd_ptr = wr_ptr - count (mod depth); issued = 0.
- Read issue: mem_read_en=1, mem_addr=rd_ptr when issued<count and (skid occupancy + in-flight) < 2. rd_ptr and issued increment on each issue.
- Read return: mem_valid is accepted only when the in-flight flag is set. Data is pushed into the 2-entry skid buffer.
- Output: out_valid reflects a non-empty skid buffer. Data pops on out_valid&&out_ready. out_last=1 on the word whose index == count-1.
- Throughput: 1 word/cycle with out_ready held high. First out_valid appears 2 cycles after DUMP entry.
- mem_write_en and mem_read_en are never asserted together. No BRAM access occurs in IDLE.
- done: single-cycle pulse the cycle after the final handshake (or the empty-stop case). busy drops in that same cycle.
- Reset mid-DUMP: any stale mem_valid after reset is ignored because the in-flight flag is clear.

Optional Feature:
Macro BRAM_CAPTURE_WRAP_CNT_EN.
- Defined: wrap_count increments on every CAPTURE write made while count==depth, saturating at 16'hFFFF, and clears on start.
- Undefined: wrap_count is tied to 0 and the counter logic is removed.

Decomposition:
- Package bram_capture_pkg: state enum (IDLE, CAPTURE, DUMP), WRAP_CNT_W=16 localparam, helper function for modular pointer subtract.
- One sub-module, capture_skid_buf: 2-entry valid/ready buffer parameterised on DATA_WIDTH, carrying a last bit.

Test Plan:
All scenarios use ADDR_WIDTH=4 (depth 16) with the BRAM wrapper behavioural model attached.
- start, 5 samples 0x0001..0x0005, stop, out_ready=1 -> outputs 0x0001..0x0005 on consecutive cycles; out_last on 0x0005; done pulse next cycle; no mem_write_en in DUMP.
- start, 20 samples 0x0000..0x0013, stop -> 16 words 0x0004..0x0013 in order; wrap_count==4 with macro, 0 without.
- Dump of 8 words with out_ready toggling 1,0,0,1 repeating -> no loss or duplication; out_data holds stable while out_valid && !out_ready; mem_read_en never makes occupancy+in-flight exceed 2.
- start then immediate stop (no samples) -> no out_valid; done pulse one cycle later; busy low.
- stop and in_valid with 0x00AA in the same cycle after 3 samples -> 4 words dumped, last = 0x00AA.
- rst asserted during DUMP with 1 read in flight -> all outputs 0 immediately; the following mem_valid produces no out_valid; a new start captures from address 0.

Source files
------------

// File: rtl/bram_capture_pkg.sv
// -----------------------------------------------------------------------------
// bram_capture_pkg
// Shared types and helpers for the BRAM capture controller.
//   state_e     : controller states (idle, capturing, dumping)
//   WRAP_CNT_W  : width of the overwritten-word counter
//   ptr_sub     : modular pointer subtraction, (a - b) mod 2**aw
// -----------------------------------------------------------------------------
package bram_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DUMP    = 2'd2
   } state_e;

   localparam int WRAP_CNT_W = 16;

   // Pointer arithmetic for a power-of-two ring; caller truncates to its own
   // pointer width.
   function automatic logic [31:0] ptr_sub(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          aw);
      logic [31:0] mask;
      mask = (32'd1 << aw) - 32'd1;
      return (a - b) & mask;
   endfunction

endpackage

// File: rtl/bram_capture_ctrl_skid.sv
// -----------------------------------------------------------------------------
// capture_skid_buf
// Two-entry valid/ready buffer between the BRAM read return and the dump
// stream. Each entry carries a data word and a last flag.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   push_i            : write one entry (caller guarantees space)
//   push_data_i/_last : entry contents
//   out_valid_o       : buffer non-empty
//   out_ready_i       : downstream accept; pop on out_valid_o && out_ready_i
//   out_data_o/_last_o: head entry (zero when empty)
//   occ_o             : current occupancy, 0..2
// -----------------------------------------------------------------------------
module capture_skid_buf #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  push_last_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_last_o,
   output logic [1:0]            occ_o
);

   logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
   logic                  last0_q, last0_d, last1_q, last1_d;
   logic [1:0]            occ_q, occ_d;
   logic                  pop;

   assign out_valid_o = (occ_q != 2'd0);
   assign out_data_o  = out_valid_o ? data0_q : '0;
   assign out_last_o  = out_valid_o & last0_q;
   assign occ_o       = occ_q;
   assign pop         = out_valid_o & out_ready_i;

   // Entry 0 is always the head; entry 1 shifts down on a pop.
   always_comb begin
      data0_d = data0_q;
      data1_d = data1_q;
      last0_d = last0_q;
      last1_d = last1_q;
      occ_d   = occ_q;
      case ({push_i, pop})
         2'b10: begin
            if (occ_q == 2'd0) begin
               data0_d = push_data_i;
               last0_d = push_last_i;
               occ_d   = 2'd1;
            end else begin
               data1_d = push_data_i;
               last1_d = push_last_i;
               occ_d   = 2'd2;
            end
         end
         2'b01: begin
            data0_d = data1_q;
            last0_d = last1_q;
            occ_d   = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               data0_d = push_data_i;
               last0_d = push_last_i;
            end else begin
               data0_d = data1_q;
               last0_d = last1_q;
               data1_d = push_data_i;
               last1_d = push_last_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data0_q <= '0;
         data1_q <= '0;
         last0_q <= 1'b0;
         last1_q <= 1'b0;
         occ_q   <= 2'd0;
      end else begin
         data0_q <= data0_d;
         data1_q <= data1_d;
         last0_q <= last0_d;
         last1_q <= last1_d;
         occ_q   <= occ_d;
      end
   end

endmodule

// File: rtl/bram_capture_ctrl.sv
// -----------------------------------------------------------------------------
// bram_capture_ctrl
// Captures a free-running sample stream into a single-port BRAM used as a
// circular buffer, then on stop dumps the captured window oldest-first on a
// valid/ready stream.
// Optional feature macro: BRAM_CAPTURE_WRAP_CNT_EN (overwritten-word counter;
// when undefined wrap_count is tied to zero).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start / stop        : capture control pulses
//   in_valid / in_data  : sample stream (no backpressure)
//   out_valid/out_ready/out_data/out_last : dump stream
//   busy, done          : status (done is a one-cycle pulse)
//   wrap_count          : number of samples written over older data
//   mem_*               : BRAM master interface, one-cycle read latency
// -----------------------------------------------------------------------------
module bram_capture_ctrl
   import bram_capture_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic [WRAP_CNT_W-1:0] wrap_count,
   output logic                  mem_write_en,
   output logic                  mem_read_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   input  logic                  mem_valid
);

   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0]      DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [CNT_W-1:0]      CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [CNT_W-1:0]      issued_q, issued_d;
   logic                  infl_q, infl_d;
   logic                  infl_last_q, infl_last_d;
   logic                  done_q, done_d;

   logic [1:0]            skid_occ;
   logic                  pop;
   logic                  push;
   logic                  read_room;

   assign pop  = out_valid & out_ready;
   // A return is only trusted if this controller issued the read; a stale
   // valid after reset is dropped here.
   assign push = mem_valid & infl_q;

   // Count the slot freed by this cycle's pop so a steady ready stream sees
   // one word per cycle while the buffer can still never overflow.
   assign read_room = (({1'b0, skid_occ} - {2'b00, pop} + {2'b00, infl_q}) < 3'd2);

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;

   always_comb begin
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      issued_d       = issued_q;
      infl_d         = 1'b0;
      infl_last_d    = 1'b0;
      done_d         = 1'b0;
      mem_write_en   = 1'b0;
      mem_read_en    = 1'b0;
      mem_addr       = '0;
      mem_write_data = '0;

      case (state_q)
         ST_IDLE: begin
            // A sample arriving with start is deliberately not written.
            if (start) begin
               state_d  = ST_CAPTURE;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               count_d  = '0;
               issued_d = '0;
            end
         end

         ST_CAPTURE: begin
            if (in_valid) begin
               mem_write_en   = 1'b1;
               mem_addr       = wr_ptr_q;
               mem_write_data = in_data;
               wr_ptr_d       = wr_ptr_q + PTR_ONE;
               if (count_q != DEPTH) begin
                  count_d = count_q + CNT_ONE;
               end
            end
            if (stop) begin
               // Uses the post-write pointer/count so a sample coinciding
               // with stop is part of the dump.
               if (count_d == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d  = ST_DUMP;
                  rd_ptr_d = ADDR_WIDTH'(ptr_sub(32'(wr_ptr_d), 32'(count_d), ADDR_WIDTH));
                  issued_d = '0;
               end
            end
         end

         ST_DUMP: begin
            if ((issued_q < count_q) && read_room) begin
               mem_read_en = 1'b1;
               mem_addr    = rd_ptr_q;
               rd_ptr_d    = rd_ptr_q + PTR_ONE;
               issued_d    = issued_q + CNT_ONE;
               infl_d      = 1'b1;
               infl_last_d = (issued_q == (count_q - CNT_ONE));
            end
            if (pop && out_last) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         issued_q    <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         issued_q    <= issued_d;
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
         done_q      <= done_d;
      end
   end

   capture_skid_buf #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (mem_read_data),
      .push_last_i (infl_last_q),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_last_o  (out_last),
      .occ_o       (skid_occ)
   );

`ifdef BRAM_CAPTURE_WRAP_CNT_EN
   logic [WRAP_CNT_W-1:0] wrap_q, wrap_d;

   always_comb begin
      wrap_d = wrap_q;
      if ((state_q == ST_IDLE) && start) begin
         wrap_d = '0;
      end else if ((state_q == ST_CAPTURE) && in_valid && (count_q == DEPTH)
                   && (wrap_q != {WRAP_CNT_W{1'b1}})) begin
         wrap_d = wrap_q + {{(WRAP_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap_q <= '0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign wrap_count = wrap_q;
`else
   assign wrap_count = '0;
`endif

endmodule

// File: tb/tb_bram_capture_ctrl.sv
`timescale 1ns/1ps
module tb_bram_capture_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          done;
   logic [15:0]   wrap_count;
   logic          mem_write_en;
   logic          mem_read_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_write_data;
   logic [DW-1:0] mem_read_data = '0;
   logic          mem_valid = 1'b0;

   bram_capture_ctrl #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .stop           (stop),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_last       (out_last),
      .busy           (busy),
      .done           (done),
      .wrap_count     (wrap_count),
      .mem_write_en   (mem_write_en),
      .mem_read_en    (mem_read_en),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data),
      .mem_valid      (mem_valid)
   );

   always #5 clk = ~clk;

   // Behavioural single-port BRAM, one-cycle read latency, no reset.
   logic [DW-1:0] bram [DEPTH];
   always @(posedge clk) begin
      if (mem_write_en) bram[mem_addr] <= mem_write_data;
      if (mem_read_en) mem_read_data <= bram[mem_addr];
      mem_valid <= mem_read_en;
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [DW-1:0] hist[$];
   logic [DW-1:0] exp_q[$];

   int rd_issued = 0, hs_cnt = 0, ovalid_cnt = 0;
   int first_v_cyc = -1, first_hs = -1, last_hs = -1;
   int stop_cyc = 0, done_seen_cyc = -1;
   bit phase_dump = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic [3:0]    pat = 4'b1001;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Output monitor / scoreboard consumer, sampled on the falling edge.
   initial forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
         rd_issued  = 0;
         hs_cnt     = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid_held", 32'(out_valid), 1);
            chk("stall_data_held", 32'(out_data), 32'(prev_data));
         end
         if (mem_write_en || mem_read_en)
            chk("rd_wr_exclusive", 32'(mem_write_en & mem_read_en), 0);
         if (!busy)
            chk("idle_no_bram_access", 32'(mem_write_en | mem_read_en), 0);
         if (phase_dump)
            chk("no_write_in_dump", 32'(mem_write_en), 0);
         if (mem_read_en) rd_issued++;
         if (out_valid) begin
            ovalid_cnt++;
            if (first_v_cyc < 0) first_v_cyc = cyc;
         end
         if (out_valid && out_ready) begin
            hs_cnt++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            if (exp_q.size() == 0) begin
               chk("extra_dump_word", 32'(exp_q.size()), 1);
            end else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               chk("dump_data", 32'(out_data), 32'(e));
               chk("dump_last", 32'(out_last), 32'(exp_q.size() == 0));
            end
         end
         if (mem_read_en)
            chk("outstanding_le_2", 32'((rd_issued - hs_cnt) <= 2), 1);
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [DW-1:0] d, input logic v);
      start    = 1'b1;
      in_valid = v;
      in_data  = d;
      hist.delete();
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic put(input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      hist.push_back(d);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_stop(input logic with_sample, input logic [DW-1:0] d);
      int n;
      stop = 1'b1;
      if (with_sample) begin
         in_valid = 1'b1;
         in_data  = d;
         hist.push_back(d);
      end
      n = (hist.size() > DEPTH) ? DEPTH : hist.size();
      exp_q.delete();
      for (int i = hist.size() - n; i < hist.size(); i++) exp_q.push_back(hist[i]);
      stop_cyc    = cyc;
      first_v_cyc = -1;
      first_hs    = -1;
      last_hs     = -1;
      tick();
      stop       = 1'b0;
      in_valid   = 1'b0;
      phase_dump = (n != 0);
   endtask

   task automatic wait_done(input string tag, input logic toggle, input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         out_ready = toggle ? pat[i % 4] : 1'b1;
         tick();
         if (done) begin
            seen = 1'b1;
            done_seen_cyc = cyc;
            chk({tag, "_busy_low_with_done"}, 32'(busy), 0);
         end
      end
      chk({tag, "_done_within_budget"}, 32'(seen), 1);
      chk({tag, "_all_words_out"}, 32'(exp_q.size()), 0);
      phase_dump = 0;
      out_ready  = 1'b0;
      tick();
      chk({tag, "_done_single_pulse"}, 32'(done), 0);
   endtask

   initial begin
      int ov_before;
      int exp_wrap;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_wrap_count", 32'(wrap_count), 0);
      chk("rst_mem_we_re", 32'({mem_write_en, mem_read_en}), 0);
      chk("rst_mem_addr_wd", 32'({mem_addr, mem_write_data}), 0);
      rst = 1'b0;
      tick();

      // 1: five samples, ready held high
      do_start('0, 1'b0);
      for (int i = 1; i <= 5; i++) put(DW'(i));
      do_stop(1'b0, '0);
      wait_done("t1", 1'b0, 40);
      chk("t1_first_valid_latency", 32'(first_v_cyc - stop_cyc), 3);
      chk("t1_back_to_back", 32'(last_hs - first_hs), 4);
      chk("t1_done_after_last", 32'(done_seen_cyc - last_hs), 1);
      $display("t1 five-sample dump finished, total=%0d", total);

      // 2: wrap after 20 samples; sample presented with start is not captured
      do_start(16'hDEAD, 1'b1);
      for (int i = 0; i < 20; i++) put(DW'(i));
      do_stop(1'b0, '0);
`ifdef BRAM_CAPTURE_WRAP_CNT_EN
      exp_wrap = 4;
`else
      exp_wrap = 0;
`endif
      chk("t2_wrap_count", 32'(wrap_count), 32'(exp_wrap));
      chk("t2_exp_depth", 32'(exp_q.size()), 16);
      wait_done("t2", 1'b0, 60);
      $display("t2 wrapped dump finished, total=%0d", total);

      // 3: stalling consumer 1,0,0,1
      do_start('0, 1'b0);
      for (int i = 0; i < 8; i++) put(16'h0100 + DW'(i));
      do_stop(1'b0, '0);
      wait_done("t3", 1'b1, 80);
      $display("t3 backpressured dump finished, total=%0d", total);

      // 4: empty capture
      do_start('0, 1'b0);
      ov_before = ovalid_cnt;
      do_stop(1'b0, '0);
      chk("t4_done_next_cycle", 32'(done), 1);
      chk("t4_busy_low", 32'(busy), 0);
      tick();
      chk("t4_done_single", 32'(done), 0);
      tick();
      chk("t4_no_out_valid", 32'(ovalid_cnt - ov_before), 0);
      $display("t4 empty stop finished, total=%0d", total);

      // 5: stop coincides with a sample
      do_start('0, 1'b0);
      for (int i = 1; i <= 3; i++) put(DW'(16'h0010 + i));
      do_stop(1'b1, 16'h00AA);
      chk("t5_exp_words", 32'(exp_q.size()), 4);
      wait_done("t5", 1'b0, 40);
      $display("t5 stop-with-sample dump finished, total=%0d", total);

      // 6: reset with a read in flight
      do_start('0, 1'b0);
      for (int i = 0; i < 6; i++) put(16'h0200 + DW'(i));
      do_stop(1'b0, '0);
      chk("t6_first_read_issued", 32'(mem_read_en), 1);
      tick();
      rst = 1'b1;
      #1;
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_out_valid", 32'(out_valid), 0);
      chk("t6_rst_mem_re_we", 32'({mem_read_en, mem_write_en}), 0);
      chk("t6_rst_done", 32'(done), 0);
      chk("t6_rst_out_data", 32'(out_data), 0);
      #1;
      rst = 1'b0;
      exp_q.delete();
      phase_dump = 0;
      ov_before = ovalid_cnt;
      repeat (3) tick();
      chk("t6_stale_valid_ignored", 32'(ovalid_cnt - ov_before), 0);
      chk("t6_idle_after_rst", 32'(busy), 0);
      do_start('0, 1'b0);
      in_valid = 1'b1;
      in_data  = 16'h0055;
      #1;
      chk("t6_restart_addr0", 32'({mem_write_en, mem_addr}), 32'({1'b1, 4'd0}));
      hist.push_back(16'h0055);
      tick();
      in_valid = 1'b1;
      in_data  = 16'h0066;
      #1;
      chk("t6_restart_addr1", 32'({mem_write_en, mem_addr}), 32'({1'b1, 4'd1}));
      hist.push_back(16'h0066);
      tick();
      in_valid = 1'b0;
      do_stop(1'b0, '0);
      wait_done("t6", 1'b0, 40);
      $display("t6 reset-mid-dump finished, total=%0d", total);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
